// File: rtl/signal_debouncer_if.sv
// signal_debouncer_if: raw level in (master drives), debounced signal/busy/glitch_cnt out (slave drives)
interface signal_debouncer_if #(
  parameter int GLITCH_W = 8
);
  logic                raw_in;
  logic                signal;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;
  modport master(output raw_in, input signal, busy, glitch_cnt);
  modport slave(input raw_in, output signal, busy, glitch_cnt);
endinterface

// File: rtl/signal_debouncer.sv
// signal_debouncer: synchronizes and debounces bus.raw_in into bus.signal; bus.busy while qualifying, bus.glitch_cnt counts aborted candidates (clk, rst sync active-high)
module signal_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit RESET_VALUE     = 1'b0,
  parameter int GLITCH_W        = 8
) (
  input logic               clk,
  input logic               rst,
  signal_debouncer_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW} state_t;
  localparam state_t RST_ST = RESET_VALUE ? ST_HIGH : ST_LOW;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   signal_q, signal_d;
  logic [GLITCH_W-1:0]    glitch_q, glitch_d, glitch_inc;
  logic                   s;
  assign s = sync_q[SYNC_STAGES-1];
  assign glitch_inc = &glitch_q ? glitch_q : glitch_q + 1'b1;
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], bus.raw_in};
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signal_d = signal_q;
    glitch_d = glitch_q;
    case (state_q)
      ST_LOW:
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CW'(1);
        end
      WAIT_HIGH:
        if (!s) begin
          state_d  = ST_LOW;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == TERM) begin
          state_d  = ST_HIGH;
          signal_d = 1'b1;
          cnt_d    = '0;
        end else
          cnt_d = cnt_q + 1'b1;
      ST_HIGH:
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CW'(1);
        end
      WAIT_LOW:
        if (s) begin
          state_d  = ST_HIGH;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == TERM) begin
          state_d  = ST_LOW;
          signal_d = 1'b0;
          cnt_d    = '0;
        end else
          cnt_d = cnt_q + 1'b1;
      default: state_d = RST_ST;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{RESET_VALUE}};
      state_q  <= RST_ST;
      cnt_q    <= '0;
      signal_q <= RESET_VALUE;
      glitch_q <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signal_q <= signal_d;
      glitch_q <= glitch_d;
    end
  end
  assign bus.signal     = signal_q;
  assign bus.busy       = state_q == WAIT_HIGH || state_q == WAIT_LOW;
  assign bus.glitch_cnt = glitch_q;
endmodule
